alu_issue_ctrl: RTL

// Front end driving the team's combinational ALU: accepts 9-bit instructions over a valid/ready

---
 rtl/alu_isa_pkg.sv | 34 +++
 rtl/alu_issue_ctrl_if.sv | 33 +++
 rtl/alu_regfile.sv | 35 +++
 rtl/alu_issue_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/alu_isa_pkg.sv
// Shared ISA definitions for the ALU issue front end and the ALU itself:
// opcode constants, instruction field layout, controller states and widths.
// Optional feature macro used by consumers of this package: ALU_ILLEGAL_TRAP_EN.
package alu_isa_pkg;

  localparam int DW     = 8;
  localparam int RIDX_W = 3;
  localparam int NREGS  = 2 ** RIDX_W;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SHF = 3'b111;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rt;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  // Opcodes with no defined ALU operation
  function automatic logic is_illegal(input logic [2:0] op);
    return (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the fetch handshake, ALU drive/return and writeback signals
// of the ALU issue controller. The slave modport is the controller's view.
interface alu_issue_ctrl_if;
  import alu_isa_pkg::*;

  logic          instr_valid;
  logic          instr_ready;
  instr_t        instr;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_op1;
  logic [DW-1:0] alu_op2;
  logic [2:0]    alu_imm;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic          wb_valid;
  logic [2:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          zero_flag;
  logic          illegal;

  modport master (
    output instr_valid, instr, alu_result, alu_zero,
    input  instr_ready, alu_opcode, alu_op1, alu_op2, alu_imm,
           wb_valid, wb_addr, wb_data, zero_flag, illegal
  );

  modport slave (
    input  instr_valid, instr, alu_result, alu_zero,
    output instr_ready, alu_opcode, alu_op1, alu_op2, alu_imm,
           wb_valid, wb_addr, wb_data, zero_flag, illegal
  );

endinterface

// File: rtl/alu_regfile.sv
// General-purpose register file: two asynchronous read ports, one
// synchronous write port, every entry cleared by reset (r0 is writable).
module alu_regfile #(
  parameter int NREGS  = 8,
  parameter int RIDX_W = 3,
  parameter int DW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RIDX_W-1:0] ra_addr,
  output logic [DW-1:0]     ra_data,
  input  logic [RIDX_W-1:0] rb_addr,
  output logic [DW-1:0]     rb_data,
  input  logic              we,
  input  logic [RIDX_W-1:0] wa,
  input  logic [DW-1:0]     wd
);

  logic [DW-1:0] mem [NREGS];

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

  // Storage: clear on reset, single write per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one instruction per four cycles, reads
// operands, drives the external combinational ALU from registers for the
// whole EXEC cycle, captures its result and writes it back.
// Optional feature: ALU_ILLEGAL_TRAP_EN traps opcodes 011/100/101 in WB.
module alu_issue_ctrl
  import alu_isa_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  alu_issue_ctrl_if.slave  bus
);

  state_t        state;
  instr_t        ir;
  logic [2:0]    opcode_q;
  logic [2:0]    imm_q;
  logic [DW-1:0] op1_q;
  logic [DW-1:0] op2_q;
  logic [DW-1:0] res_q;
  logic          z_q;
  logic          zero_q;
  logic [DW-1:0] rf_a;
  logic [DW-1:0] rf_b;
  logic          trap;
  logic          wb_fire;

  alu_regfile #(
    .NREGS  (NREGS),
    .RIDX_W (RIDX_W),
    .DW     (DW)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (ir.rd),
    .ra_data (rf_a),
    .rb_addr (ir.rt),
    .rb_data (rf_b),
    .we      (wb_fire),
    .wa      (ir.rd),
    .wd      (res_q)
  );

`ifdef ALU_ILLEGAL_TRAP_EN
  assign trap = (state == WB) && is_illegal(ir.op);
`else
  assign trap = 1'b0;
`endif

  assign wb_fire = (state == WB) && !trap;

  assign bus.instr_ready = (state == IDLE) && rst_n;
  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_op1     = op1_q;
  assign bus.alu_op2     = op2_q;
  assign bus.alu_imm     = imm_q;
  assign bus.wb_valid    = wb_fire;
  assign bus.wb_addr     = wb_fire ? ir.rd : 3'd0;
  assign bus.wb_data     = wb_fire ? res_q : '0;
  assign bus.zero_flag   = zero_q;
  assign bus.illegal     = trap;

  // Sequencer: latch an instruction in IDLE, then walk READ/EXEC/WB once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            ir    <= bus.instr;
            state <= READ;
          end
        end
        READ:    state <= EXEC;
        EXEC:    state <= WB;
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operand fetch into ALU drive registers, result capture, flag update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= '0;
      imm_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      res_q    <= '0;
      z_q      <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      if (state == READ) begin
        opcode_q <= ir.op;
        imm_q    <= ir.rt;
        op1_q    <= rf_a;
        op2_q    <= rf_b;
      end
      if (state == EXEC) begin
        res_q <= bus.alu_result;
        z_q   <= bus.alu_zero;
      end
      if (wb_fire) begin
        zero_q <= z_q;
      end
    end
  end

endmodule
